// File: rtl/fifo_wr_status.sv
// Write-side status for an async FIFO: read-pointer synchronizer, full, level, almost_full.
// Define FIFO_WR_STATUS_OVERFLOW_EN to add a sticky overflow flag (write attempted while full).
module fifo_wr_status #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LVL   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic [N-1:0] wptr,
    input  logic [N-1:0] rptr_async,
    output logic         full,
    output logic         almost_full,
    output logic [N-1:0] level
`ifdef FIFO_WR_STATUS_OVERFLOW_EN
    ,
    output logic         overflow
`endif
);

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [N-1:0] rq [SYNC_STAGES];
    logic [N-1:0] rq_s;
    logic [N-1:0] level_next;

    // NOTE: plain register chain with no logic between stages; reset clears every
    // stage so a stale read pointer cannot survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) rq[k] <= '0;
        end else begin
            rq[0] <= rptr_async;
            for (int k = 1; k < SYNC_STAGES; k++) rq[k] <= rq[k-1];
        end
    end

    assign rq_s = rq[SYNC_STAGES-1];

    // Full when the pointers differ only in the two MSBs (write is one lap ahead).
    assign full = (wptr == {~rq_s[N-1], ~rq_s[N-2], rq_s[N-3:0]});

    // Unsigned N-bit subtraction absorbs the wrap of either pointer.
    assign level_next = gray2bin(wptr) - gray2bin(rq_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= level_next;
            almost_full <= (level_next >= N'(AFULL_LVL));
        end
    end

`ifdef FIFO_WR_STATUS_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (rst)              overflow <= 1'b0;
        else if (inc && full) overflow <= 1'b1;
    end
`else
    logic unused_inc;
    assign unused_inc = inc;
`endif

endmodule

// File: tb/tb_fifo_wr_status.sv
// Randomized and directed bench for fifo_wr_status against a pointer-distance model.
// Overflow checks are active only when FIFO_WR_STATUS_OVERFLOW_EN is defined.
module tb_fifo_wr_status;
    localparam int N     = 4;
    localparam int S     = 2;
    localparam int AFULL = 6;
    localparam int MASK  = (1 << N) - 1;
    localparam int DEPTH = 1 << (N - 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         inc = 1'b0;
    logic [N-1:0] wptr = '0;
    logic [N-1:0] rptr_async = '0;
    logic         full, almost_full;
    logic [N-1:0] level;
    logic         ovf_obs;

    int errors = 0;
    int checks = 0;

    // Model: binary pointers, delay line of sampled read pointers, expected registers.
    int m_wb, m_rb;
    int rq_q[$];
    int m_level;
    bit m_af, m_ovf;
    bit pre_full_exp, pre_full_obs;

    fifo_wr_status #(.N(N), .SYNC_STAGES(S), .AFULL_LVL(AFULL)) dut (
        .clk(clk), .rst(rst), .inc(inc), .wptr(wptr), .rptr_async(rptr_async),
        .full(full), .almost_full(almost_full), .level(level)
`ifdef FIFO_WR_STATUS_OVERFLOW_EN
        , .overflow(ovf_obs)
`endif
    );

`ifndef FIFO_WR_STATUS_OVERFLOW_EN
    assign ovf_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic logic [N-1:0] to_gray(input int b);
        logic [N-1:0] v;
        v = N'(b & MASK);
        return v ^ (v >> 1);
    endfunction

    function automatic bit model_full();
        return ((m_wb - rq_q[S-1]) & MASK) == DEPTH;
    endfunction

    // One clock: drive at negedge, capture combinational full, step model across the edge.
    task automatic cycle(input int wb, input int rb, input bit inc_v, input bit rst_v);
        int rs, nl;
        bit naf, novf;
        @(negedge clk);
        m_wb = wb & MASK; m_rb = rb & MASK;
        wptr = to_gray(m_wb); rptr_async = to_gray(m_rb); inc = inc_v; rst = rst_v;
        #1;
        pre_full_exp = model_full();
        pre_full_obs = full;
        rs = rq_q[S-1];
        if (rst_v) begin
            nl = 0; naf = 0; novf = 0;
            foreach (rq_q[k]) rq_q[k] = 0;
        end else begin
            nl   = (m_wb - rs) & MASK;
            naf  = (nl >= AFULL);
            novf = m_ovf | (inc_v & pre_full_exp);
            rq_q.push_front(m_rb);
            void'(rq_q.pop_back());
        end
        @(posedge clk);
        #1;
        m_level = nl; m_af = naf;
`ifdef FIFO_WR_STATUS_OVERFLOW_EN
        m_ovf = novf;
`else
        m_ovf = 0;
`endif
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b want=0", almost_full); end
        checks++; if (level !== 4'b0000) begin errors++; $display("FAIL reset_level got=%b want=0000", level); end
        checks++; if (ovf_obs !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf_obs); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int w = 1; w <= 8; w++) begin
            cycle(w, 0, 1, 0);
            checks++; if (pre_full_obs !== pre_full_exp) begin errors++; $display("FAIL fill_full w=%0d got=%b want=%b", w, pre_full_obs, pre_full_exp); end
            checks++; if (level !== N'(m_level)) begin errors++; $display("FAIL fill_level w=%0d got=%0d want=%0d", w, level, m_level); end
        end
        checks++; if (pre_full_obs !== 1'b1) begin errors++; $display("FAIL fill_full_comb got=%b want=1", pre_full_obs); end
        checks++; if (level !== 4'b1000) begin errors++; $display("FAIL fill_level8 got=%b want=1000", level); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_afull got=%b want=1", almost_full); end
    endtask

    task automatic test_release();
        cycle(8, 1, 0, 0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL release_t full got=%b want=1", full); end
        cycle(8, 1, 0, 0);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL release_t1 full got=%b want=0", full); end
        cycle(8, 1, 0, 0);
        checks++; if (level !== 4'b0111) begin errors++; $display("FAIL release_t2 level got=%b want=0111", level); end
    endtask

    task automatic test_threshold();
        do_reset();
        for (int w = 1; w <= 6; w++) begin
            cycle(w, 0, 1, 0);
            checks++; if (almost_full !== m_af) begin errors++; $display("FAIL thr_afull w=%0d got=%b want=%b", w, almost_full, m_af); end
            if (w == 5) begin
                checks++; if (almost_full !== 1'b0 || level !== 4'b0101) begin errors++; $display("FAIL thr_5 af=%b lvl=%b want af=0 lvl=0101", almost_full, level); end
            end
        end
        checks++; if (almost_full !== 1'b1 || level !== 4'b0110) begin errors++; $display("FAIL thr_6 af=%b lvl=%b want af=1 lvl=0110", almost_full, level); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(15, 9, 0, 0);
        checks++; if (level !== 4'b0110) begin errors++; $display("FAIL wrap_pre level got=%b want=0110", level); end
        cycle(16, 9, 1, 0);
        checks++; if (level !== 4'b0111) begin errors++; $display("FAIL wrap_post level got=%b want=0111", level); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full got=%b want=0", full); end
    endtask

`ifdef FIFO_WR_STATUS_OVERFLOW_EN
    task automatic test_overflow();
        do_reset();
        for (int w = 1; w <= 8; w++) cycle(w, 0, 1, 0);
        checks++; if (ovf_obs !== 1'b0) begin errors++; $display("FAIL ovf_pre got=%b want=0", ovf_obs); end
        cycle(8, 0, 1, 0);
        checks++; if (ovf_obs !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", ovf_obs); end
        for (int i = 0; i < 3; i++) cycle(8, 1, 0, 0);
        checks++; if (full !== 1'b0 || ovf_obs !== 1'b1) begin errors++; $display("FAIL ovf_hold full=%b ovf=%b want full=0 ovf=1", full, ovf_obs); end
        cycle(0, 0, 0, 1);
        checks++; if (ovf_obs !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", ovf_obs); end
    endtask
`endif

    task automatic test_random();
        int wb, rb;
        bit wr, inc_v;
        do_reset();
        wb = 0; rb = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(99) == 0) begin
                cycle(wb, int'($urandom_range(MASK)), 1'($urandom_range(1)), 1);
                wb = 0; rb = 0;
            end else begin
                wr    = ($urandom_range(2) != 0) && !model_full();
                inc_v = wr || (model_full() && $urandom_range(3) == 0);
                if (wr) wb = (wb + 1) & MASK;
                if (rb != m_wb && $urandom_range(2) == 0) rb = (rb + 1) & MASK;
                cycle(wb, rb, inc_v, 0);
            end
            checks++; if (pre_full_obs !== pre_full_exp) begin errors++; $display("FAIL rnd_full_pre c=%0d got=%b want=%b", c, pre_full_obs, pre_full_exp); end
            checks++; if (level !== N'(m_level)) begin errors++; $display("FAIL rnd_level c=%0d got=%0d want=%0d", c, level, m_level); end
            checks++; if (almost_full !== m_af) begin errors++; $display("FAIL rnd_afull c=%0d got=%b want=%b", c, almost_full, m_af); end
            checks++; if (full !== model_full()) begin errors++; $display("FAIL rnd_full_post c=%0d got=%b want=%b", c, full, model_full()); end
            checks++; if (ovf_obs !== m_ovf) begin errors++; $display("FAIL rnd_ovf c=%0d got=%b want=%b", c, ovf_obs, m_ovf); end
        end
    endtask

    initial begin
        for (int k = 0; k < S; k++) rq_q.push_back(0);
        m_wb = 0; m_rb = 0; m_level = 0; m_af = 0; m_ovf = 0;
        test_reset();
        test_fill();
        test_release();
        test_threshold();
        test_wrap();
`ifdef FIFO_WR_STATUS_OVERFLOW_EN
        test_overflow();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_status.md
FIFO_WR_STATUS -- requirements
Module: fifo_wr_status

Interface
REQ-001 Parameter N, default 4: pointer width in bits; FIFO depth is 2^(N-1); N SHALL be >= 3.
REQ-002 Parameter SYNC_STAGES, default 2: depth of the remote-pointer synchronizer; SHALL be >= 2.
REQ-003 Parameter AFULL_LVL, default 6: fill level at or above which almost_full asserts; range 1..2^(N-1).
REQ-004 clk  input  1  single clock (write domain); all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 inc  input  1  write request from producer, same qualifier as fed to the write gray counter.
REQ-007 wptr  input  N  local write pointer, Gray-coded, registered in clk domain.
REQ-008 rptr_async  input  N  remote read pointer, Gray-coded, asynchronous to clk.
REQ-009 full  output  1  FIFO full; gates the write counter's increment.
REQ-010 almost_full  output  1  registered, level >= AFULL_LVL.
REQ-011 level  output  N  registered fill level, 0..2^(N-1).
REQ-012 overflow  output  1  sticky error flag; present only with FIFO_WR_STATUS_OVERFLOW_EN.

Function
REQ-013 Synchronizer: rq[0] <= rptr_async; rq[k] <= rq[k-1] for k = 1..SYNC_STAGES-1; rq_s = rq[SYNC_STAGES-1]; no logic between stages.
REQ-014 A change on rptr_async sampled at edge t SHALL appear on rq_s after edge t+SYNC_STAGES-1.
REQ-015 full SHALL be combinational from registers only: full = (wptr == {~rq_s[N-1], ~rq_s[N-2], rq_s[N-3:0]}); zero-cycle latency from wptr change.
REQ-016 Binary conversion: bit i of bin = XOR of gray bits N-1..i, applied to wptr and rq_s.
REQ-017 level <= (bin(wptr) - bin(rq_s)) mod 2^N each cycle; one-cycle latency; wrap of either pointer SHALL be handled by the modulo arithmetic.
REQ-018 almost_full <= (next level >= AFULL_LVL); updates on the same edge as level.
REQ-019 level and almost_full are advisory, lag by one cycle and may overestimate fill (stale rq_s); full is the only authoritative flow-control output.
REQ-020 Simultaneous remote read and local write: each pointer is treated independently; no priority logic.
REQ-021 inc while full SHALL NOT alter any output other than overflow; pointer advancement is outside this block.

Reset
REQ-022 On rst at an edge: all rq stages <= 0, level <= 0, almost_full <= 0, overflow <= 0.
REQ-023 With wptr = 0 and rq_s = 0 after reset, full SHALL read 0.
REQ-024 Reset mid-operation SHALL clear the synchronizer; both FIFO sides are reset together, and values on rptr_async during rst are ignored.

Configuration
REQ-025 Macro FIFO_WR_STATUS_OVERFLOW_EN defined: overflow port exists; overflow <= 1 on any edge with inc & full & ~rst; holds until rst.
REQ-026 Macro undefined: overflow port and its register are absent; all other behaviour identical.

Verification (N=4, SYNC_STAGES=2, AFULL_LVL=6)
REQ-027 Reset: rst=1 for 2 cycles, rptr_async=0000 -> full=0, almost_full=0, level=0000, overflow=0.
REQ-028 Fill: rptr_async=0000, drive wptr gray sequence to bin 8 (gray 1100) -> full=1 combinationally; level=1000 and almost_full=1 one edge later.
REQ-029 Release: from full state, rptr_async 0000->0001 before edge t -> full=0 after edge t+1, level=0111 after edge t+2.
REQ-030 Threshold: level steps 5->6 -> almost_full 0 at level 0101, 1 on the edge where level becomes 0110.
REQ-031 Wrap: wptr gray 1000 (bin 15) -> 0000 (bin 0), rq_s gray 1101 (bin 9) -> level 0110 then 0111; full=0.
REQ-032 Overflow (macro defined): inc=1 for one cycle while full=1 -> overflow=1 next edge, stays 1 after full drops, clears only on rst; macro undefined -> port absent, build passes.
